// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the fetch-stage instruction
//                buffer refill logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Buffer geometry: four 16-byte lines covering the 6-bit BIP window
  localparam int LINE_BYTES  = 16;
  localparam int NUM_LINES   = 4;

  // Byte-address bits that select the buffer line
  localparam int LINE_IDX_HI = 5;
  localparam int LINE_IDX_LO = 4;

  // Refill controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fill_state_e;

  // Decode a line index into a one-hot line mask
  function automatic logic [NUM_LINES-1:0] line_onehot(input logic [1:0] idx);
    line_onehot      = '0;
    line_onehot[idx] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ibuf_valid_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_valid_tracker
//  Description : Per-line valid bits of the instruction buffer with flush,
//                clear (line freed by fetch 2) and set (line written) ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibuf_valid_tracker
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NUM_LINES-1:0] set_mask,
  input  logic [NUM_LINES-1:0] clr_mask,
  output logic [NUM_LINES-1:0] valid
);

  logic [NUM_LINES-1:0] r_valid;

  // Flush wins; otherwise clear freed lines and set written ones (never the same line)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_valid <= '0;
    else if (flush)
      r_valid <= '0;
    else
      r_valid <= (r_valid & ~clr_mask) | set_mask;
  end

  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/ibuf_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_fill_ctrl
//  Description : Refill controller for the 4 x 16 B instruction buffer. Issues
//                in-order line requests to the I-cache, writes returned lines
//                into their slot, frees lines as fetch 2 advances and flushes
//                on control-flow redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module ibuf_fill_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cf_valid,
  input  logic [ADDR_W-1:0]    cf_target,
  input  logic                 adv,
  input  logic [5:0]           old_bip,
  input  logic [5:0]           new_bip,
  output logic                 ic_req_valid,
  output logic [ADDR_W-1:0]    ic_req_addr,
  input  logic                 ic_req_ready,
  input  logic                 ic_rsp_valid,
  input  logic [127:0]         ic_rsp_data,
  output logic [NUM_LINES-1:0] line_wr_en,
  output logic [127:0]         line_wr_data,
  output logic [NUM_LINES-1:0] line_valid
);

  fill_state_e          r_state;
  fill_state_e          w_state_nxt;
  logic [1:0]           r_fill_ptr;
  logic [ADDR_W-1:0]    r_fill_addr;
  logic [1:0]           r_pend_slot;
  logic [NUM_LINES-1:0] w_valid;
  logic                 w_req_valid;
  logic                 w_req_hs;
  logic                 w_wr;
  logic [NUM_LINES-1:0] w_clr_mask;
  logic [1:0]           w_old_line;
  logic [1:0]           w_new_line;
  logic                 w_unused;

  // Byte-offset bits inside a line are never needed here
  assign w_unused = ^{cf_target[3:0], old_bip[3:0], new_bip[3:0]};

  assign w_old_line = old_bip[LINE_IDX_HI:LINE_IDX_LO];
  assign w_new_line = new_bip[LINE_IDX_HI:LINE_IDX_LO];

  // Request only into a free slot; holds while the cache stalls since nothing
  // but a redirect can change the slot under the pointer
  assign w_req_valid  = (r_state == ST_FILL) && !w_valid[r_fill_ptr];
  assign w_req_hs     = w_req_valid && ic_req_ready;
  assign w_wr         = (r_state == ST_WAIT) && ic_rsp_valid && !cf_valid;

  assign ic_req_valid = w_req_valid;
  assign ic_req_addr  = r_fill_addr;
  assign line_wr_en   = w_wr ? line_onehot(r_pend_slot) : '0;
  assign line_wr_data = ic_rsp_data;
  assign line_valid   = w_valid;

  // Free the line fetch 2 just left; a redirect flushes everything instead
  assign w_clr_mask = (adv && !cf_valid && (w_old_line != w_new_line))
                    ? line_onehot(w_old_line) : '0;

  ibuf_valid_tracker u_valid (
    .clk      (clk),
    .reset    (reset),
    .flush    (cf_valid),
    .set_mask (line_wr_en),
    .clr_mask (w_clr_mask),
    .valid    (w_valid)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state: a redirect must drain any request still owed a response
  always_comb begin
    w_state_nxt = r_state;
    if (cf_valid) begin
      if (((r_state == ST_WAIT || r_state == ST_DRAIN) && !ic_rsp_valid) ||
          ((r_state == ST_FILL) && w_req_hs))
        w_state_nxt = ST_DRAIN;
      else
        w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_IDLE;
        ST_FILL:  if (w_req_hs)     w_state_nxt = ST_WAIT;
        ST_WAIT:  if (ic_rsp_valid) w_state_nxt = ST_FILL;
        ST_DRAIN: if (ic_rsp_valid) w_state_nxt = ST_FILL;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fill pointer/address: reload on redirect, step one line per accepted request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_ptr  <= '0;
      r_fill_addr <= '0;
      r_pend_slot <= '0;
    end else if (cf_valid) begin
      r_fill_ptr  <= cf_target[LINE_IDX_HI:LINE_IDX_LO];
      r_fill_addr <= {cf_target[ADDR_W-1:LINE_IDX_LO], 4'h0};
    end else if (w_req_hs) begin
      r_pend_slot <= r_fill_ptr;
      r_fill_ptr  <= r_fill_ptr + 2'd1;
      r_fill_addr <= r_fill_addr + ADDR_W'(LINE_BYTES);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ibuf_fill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibuf_fill_ctrl
//  Description : Directed self-checking bench for ibuf_fill_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ibuf_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cf_valid;
  logic [31:0]  cf_target;
  logic         adv;
  logic [5:0]   old_bip;
  logic [5:0]   new_bip;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_rsp_valid;
  logic [127:0] ic_rsp_data;
  logic [3:0]   line_wr_en;
  logic [127:0] line_wr_data;
  logic [3:0]   line_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  ibuf_fill_ctrl #(.ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .cf_valid     (cf_valid),
    .cf_target    (cf_target),
    .adv          (adv),
    .old_bip      (old_bip),
    .new_bip      (new_bip),
    .ic_req_valid (ic_req_valid),
    .ic_req_addr  (ic_req_addr),
    .ic_req_ready (ic_req_ready),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_data  (ic_rsp_data),
    .line_wr_en   (line_wr_en),
    .line_wr_data (line_wr_data),
    .line_valid   (line_valid)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    cf_valid     = 1'b0;
    adv          = 1'b0;
    ic_rsp_valid = 1'b0;
    ic_req_ready = 1'b0;
  endtask

  // One cycle with ready high; the request must be up at the given address
  task automatic req_accept(input logic [31:0] addr);
    @(negedge clk); drive_idle(); ic_req_ready = 1'b1; #1;
    check("req_valid", ic_req_valid, 1'b1);
    check("req_addr",  ic_req_addr,  addr);
  endtask

  // Two-cycle latency response landing in the given slot
  task automatic rsp_write(input logic [1:0] slot, input logic [127:0] data);
    logic [3:0] m;
    m = 4'b0001 << slot;
    @(negedge clk); drive_idle(); #1;
    check("wait_no_wr", line_wr_en, 4'h0);
    @(negedge clk); drive_idle(); ic_rsp_valid = 1'b1; ic_rsp_data = data; #1;
    check("wr_en",   line_wr_en,   m);
    check("wr_data", line_wr_data, data);
  endtask

  initial begin
    reset = 1'b0; drive_idle();
    cf_target = '0; old_bip = '0; new_bip = '0; ic_rsp_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_line_valid", line_valid,   4'h0);
    check("rst_req_valid",  ic_req_valid, 1'b0);
    check("rst_wr_en",      line_wr_en,   4'h0);
    @(negedge clk); reset = 1'b1; #1;
    check("idle_req", ic_req_valid, 1'b0);

    // Redirect into 0x1000_0024 and fill all four lines in order
    @(negedge clk); drive_idle(); cf_valid = 1'b1; cf_target = 32'h1000_0024; #1;
    check("cf_cycle_req", ic_req_valid, 1'b0);
    req_accept(32'h1000_0020); rsp_write(2'd2, 128'hA2);
    req_accept(32'h1000_0030); rsp_write(2'd3, 128'hA3);
    req_accept(32'h1000_0040); rsp_write(2'd0, 128'hA0);
    req_accept(32'h1000_0050); rsp_write(2'd1, 128'hA1);
    @(negedge clk); drive_idle(); ic_req_ready = 1'b1; #1;
    check("full_valid", line_valid,   4'hF);
    check("full_req",   ic_req_valid, 1'b0);

    // Advance inside a line frees nothing; crossing 2->3 frees line 2
    @(negedge clk); drive_idle(); adv = 1'b1; old_bip = 6'h20; new_bip = 6'h2C; #1;
    @(negedge clk); drive_idle(); adv = 1'b1; old_bip = 6'h2C; new_bip = 6'h31; #1;
    check("no_cross_valid", line_valid, 4'hF);
    @(negedge clk); drive_idle(); #1;
    check("freed_valid", line_valid,   4'hB);
    check("refill_req",  ic_req_valid, 1'b1);
    check("refill_addr", ic_req_addr,  32'h1000_0060);
    req_accept(32'h1000_0060);

    // Redirect while waiting: the owed response must be dropped
    @(negedge clk); drive_idle(); cf_valid = 1'b1; cf_target = 32'h2000_0000; #1;
    check("cf_wait_wr", line_wr_en, 4'h0);
    @(negedge clk); drive_idle(); #1;
    check("flush_valid", line_valid,   4'h0);
    check("drain_req",   ic_req_valid, 1'b0);
    @(negedge clk); drive_idle(); ic_rsp_valid = 1'b1; ic_rsp_data = 128'hDEAD; #1;
    check("drain_wr", line_wr_en, 4'h0);
    req_accept(32'h2000_0000);

    // Redirect coinciding with the response: no write
    @(negedge clk); drive_idle(); ic_rsp_valid = 1'b1; cf_valid = 1'b1; cf_target = 32'h3000_0010; #1;
    check("cf_rsp_wr", line_wr_en, 4'h0);
    @(negedge clk); drive_idle(); #1;
    check("cf_rsp_valid", line_valid,   4'h0);
    check("cf_rsp_req",   ic_req_valid, 1'b1);
    check("cf_rsp_addr",  ic_req_addr,  32'h3000_0010);

    // Ready low for three cycles in total, accepted on the fourth
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive_idle(); #1;
      check("stall_req",  ic_req_valid, 1'b1);
      check("stall_addr", ic_req_addr,  32'h3000_0010);
    end
    req_accept(32'h3000_0010);
    rsp_write(2'd1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
    @(negedge clk); drive_idle(); #1;
    check("slot1_valid", line_valid,  4'h2);
    check("next_addr",   ic_req_addr, 32'h3000_0020);

    // Redirect coinciding with a handshake: the request is stale and drained
    @(negedge clk); drive_idle(); ic_req_ready = 1'b1; cf_valid = 1'b1; cf_target = 32'h4000_0030; #1;
    check("hs_cf_req_held", ic_req_valid, 1'b1);
    @(negedge clk); drive_idle(); #1;
    check("hs_cf_drain_req", ic_req_valid, 1'b0);
    @(negedge clk); drive_idle(); ic_rsp_valid = 1'b1; #1;
    check("hs_cf_drain_wr", line_wr_en, 4'h0);
    @(negedge clk); drive_idle(); #1;
    check("hs_cf_new_req",  ic_req_valid, 1'b1);
    check("hs_cf_new_addr", ic_req_addr,  32'h4000_0030);
    req_accept(32'h4000_0030);

    // Asynchronous reset mid-wait; the late response is ignored
    @(negedge clk); drive_idle(); reset = 1'b0; #1;
    check("arst_req", ic_req_valid, 1'b0);
    @(negedge clk); drive_idle();
    @(negedge clk); drive_idle(); reset = 1'b1; #1;
    check("rel_req", ic_req_valid, 1'b0);
    @(negedge clk); drive_idle(); ic_rsp_valid = 1'b1; ic_req_ready = 1'b1; #1;
    check("late_rsp_wr",  line_wr_en,   4'h0);
    check("late_rsp_req", ic_req_valid, 1'b0);
    @(negedge clk); drive_idle(); #1;
    check("post_rst_valid", line_valid,   4'h0);
    check("post_rst_req",   ic_req_valid, 1'b0);
    @(negedge clk); drive_idle(); cf_valid = 1'b1; cf_target = 32'h0000_0130; #1;
    @(negedge clk); drive_idle(); #1;
    check("restart_req",  ic_req_valid, 1'b1);
    check("restart_addr", ic_req_addr,  32'h0000_0130);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
